// File: rtl/etroc_afc_pkg.sv
// Shared constants and state encoding for the ETROC PLL automatic frequency calibration.
package etroc_afc_pkg;

    localparam int CAP_W      = 6;
    localparam int CNT_W      = 12;
    localparam int WIN_CYC    = 1024;
    localparam int SETTLE_CYC = 256;
    localparam int TARGET     = 256;

    localparam int WIN_W    = $clog2(WIN_CYC);
    localparam int SETTLE_W = $clog2(SETTLE_CYC);
    localparam int TMR_W    = (WIN_W > SETTLE_W) ? WIN_W : SETTLE_W;
    localparam int IDX_W    = $clog2(CAP_W);

    // Search always starts from mid-scale: MSB set, all others clear.
    localparam logic [CAP_W-1:0] CAP_RESET = {1'b1, {(CAP_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        DECIDE  = 3'd3,
        DONE    = 3'd4
    } afc_state_t;

endpackage

// File: rtl/etroc_afc_freq_meter.sv
// Feedback-toggle frequency meter: 2-FF synchroniser, both-edge detect, saturating windowed counter.
module etroc_afc_freq_meter
    import etroc_afc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fb_tog,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // [0],[1] resolve metastability; [2] holds the previous synchronised level for edge detect.
    logic [2:0]       sync_reg;
    logic [CNT_W-1:0] count_reg;
    logic             edge_seen;

    assign edge_seen = sync_reg[2] ^ sync_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            count_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], fb_tog};
            if (clr) begin
                count_reg <= '0;
            end else if (en && edge_seen && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/etroc_pll_afc_ctrl.sv
// AFC controller: MSB-first successive approximation of the VCO cap-bank code with static override.
// Optional error readback ports are enabled with `define ETROC_AFC_ERR_OUT_EN.
module etroc_pll_afc_ctrl
    import etroc_afc_pkg::*;
(
    input  logic             CLK40REF,
    input  logic             RSTn,
    input  logic             AFC_Start,
    input  logic             AFC_OverrideCtrl,
    input  logic [CAP_W-1:0] AFC_OverrideCtrl_val,
    input  logic             fbTog,
    output logic [CAP_W-1:0] AFC_calCap,
    output logic             AFC_busy,
    output logic             AFC_done
`ifdef ETROC_AFC_ERR_OUT_EN
    ,
    output logic signed [CNT_W:0] AFC_err,
    output logic             AFC_errValid
`endif
);

    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(CAP_W - 1);

    afc_state_t       state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic [CAP_W-1:0] cal_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             start_reg;

    logic             start_edge;
    logic [CNT_W-1:0] meas_count;
    logic             too_fast;
    logic [CAP_W-1:0] decide_code;

    etroc_afc_freq_meter u_freq_meter (
        .clk    (CLK40REF),
        .rst_n  (RSTn),
        .fb_tog (fbTog),
        .clr    (state_reg == SETTLE),
        .en     (state_reg == MEASURE),
        .count  (meas_count)
    );

    assign start_edge = AFC_Start & ~start_reg;
    assign too_fast   = meas_count > CNT_W'(TARGET);

    // Resolve the current trial bit, then arm the next lower one if any remain.
    always_comb begin
        decide_code              = cal_reg;
        decide_code[bit_idx_reg] = too_fast;
        if (bit_idx_reg != '0) begin
            decide_code[bit_idx_reg - IDX_W'(1)] = 1'b1;
        end
    end

    always_ff @(posedge CLK40REF or negedge RSTn) begin
        if (!RSTn) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            cal_reg     <= CAP_RESET;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            start_reg   <= 1'b0;
        end else begin
            start_reg <= AFC_Start;
            // Override dominates everything, including a simultaneous start edge.
            if (AFC_OverrideCtrl) begin
                state_reg   <= IDLE;
                timer_reg   <= '0;
                bit_idx_reg <= '0;
                cal_reg     <= AFC_OverrideCtrl_val;
                busy_reg    <= 1'b0;
                done_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE, DONE: begin
                        if (start_edge) begin
                            state_reg   <= SETTLE;
                            timer_reg   <= '0;
                            bit_idx_reg <= IDX_MSB;
                            cal_reg     <= CAP_RESET;
                            busy_reg    <= 1'b1;
                            done_reg    <= 1'b0;
                        end
                    end
                    SETTLE: begin
                        if (timer_reg == SETTLE_LAST) begin
                            state_reg <= MEASURE;
                            timer_reg <= '0;
                        end else begin
                            timer_reg <= timer_reg + TMR_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (timer_reg == WIN_LAST) begin
                            state_reg <= DECIDE;
                            timer_reg <= '0;
                        end else begin
                            timer_reg <= timer_reg + TMR_W'(1);
                        end
                    end
                    DECIDE: begin
                        cal_reg <= decide_code;
                        if (bit_idx_reg != '0) begin
                            bit_idx_reg <= bit_idx_reg - IDX_W'(1);
                            state_reg   <= SETTLE;
                        end else begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign AFC_calCap = cal_reg;
    assign AFC_busy   = busy_reg;
    assign AFC_done   = done_reg;

`ifdef ETROC_AFC_ERR_OUT_EN
    localparam logic signed [CNT_W:0] ERR_TARGET = (CNT_W+1)'(TARGET);

    logic signed [CNT_W:0] err_reg;
    logic                  err_valid_reg;
    logic                  deciding;

    assign deciding = (state_reg == DECIDE) && !AFC_OverrideCtrl;

    always_ff @(posedge CLK40REF or negedge RSTn) begin
        if (!RSTn) begin
            err_reg       <= '0;
            err_valid_reg <= 1'b0;
        end else begin
            err_valid_reg <= deciding;
            if (deciding) begin
                err_reg <= $signed({1'b0, meas_count}) - ERR_TARGET;
            end
        end
    end

    assign AFC_err      = err_reg;
    assign AFC_errValid = err_valid_reg;
`endif

endmodule

// File: tb/tb_etroc_pll_afc_ctrl.sv
// Self-checking bench for etroc_pll_afc_ctrl: VCO model (count = 400-4*code), search model, directed tests.
module tb_etroc_pll_afc_ctrl;

    localparam int TRIAL_CYC  = 256 + 1024 + 1;
    localparam int SEARCH_CYC = 6 * TRIAL_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ovr = 1'b0;
    logic [5:0]  ovr_val = 6'h00;
    logic        fb = 1'b0;
    logic [5:0]  cal;
    logic        busy;
    logic        done;
`ifdef ETROC_AFC_ERR_OUT_EN
    logic signed [12:0] err;
    logic               err_valid;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    etroc_pll_afc_ctrl dut (
        .CLK40REF             (clk),
        .RSTn                 (rst_n),
        .AFC_Start            (start),
        .AFC_OverrideCtrl     (ovr),
        .AFC_OverrideCtrl_val (ovr_val),
        .fbTog                (fb),
        .AFC_calCap           (cal),
        .AFC_busy             (busy),
        .AFC_done             (done)
`ifdef ETROC_AFC_ERR_OUT_EN
        ,
        .AFC_err              (err),
        .AFC_errValid         (err_valid)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // VCO model: edges per 1024-cycle window = 400 - 4*code, or none when stuck.
    bit vco_stuck = 1'b0;
    int phase = 0;

    function automatic int vco_count(input logic [5:0] code, input bit stuck);
        return stuck ? 0 : (400 - 4 * int'(code));
    endfunction

    always @(posedge clk) begin
        #2;
        if (!vco_stuck) begin
            phase += vco_count(cal, 1'b0);
            if (phase >= 1024) begin
                phase -= 1024;
                fb = ~fb;
            end
        end
    end

    // Search model: the sequence of trial codes and the final result, by plain binary search.
    logic [5:0] m_trials [6];
    logic [5:0] m_result;

    task automatic plan_search(input bit stuck);
        logic [5:0] r;
        logic [5:0] trial;
        r = 6'h00;
        for (int b = 5; b >= 0; b--) begin
            trial = r | (6'h01 << b);
            m_trials[5-b] = trial;
            if (vco_count(trial, stuck) > 256) r = trial;
        end
        m_result = r;
    endtask

    // Cycle-level expectation of the outputs, derived from the trial plan.
    logic [5:0] exp_cal = 6'h20;
    bit         exp_busy = 1'b0;
    bit         exp_done = 1'b0;
    bit         exp_evalid = 1'b0;
    int         exp_err = 0;
    bit         m_run = 1'b0;
    int         m_rel = 0;
    bit         m_prev_start = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_cal = 6'h20; exp_busy = 1'b0; exp_done = 1'b0;
            exp_evalid = 1'b0; exp_err = 0;
            m_run = 1'b0; m_rel = 0; m_prev_start = 1'b0;
        end else begin
            exp_evalid = 1'b0;
            if (ovr) begin
                exp_cal = ovr_val; exp_busy = 1'b0; exp_done = 1'b0; m_run = 1'b0;
            end else if (m_run) begin
                m_rel++;
                if (m_rel > TRIAL_CYC && ((m_rel - 1) % TRIAL_CYC) == 0) begin
                    exp_evalid = 1'b1;
                    exp_err = vco_count(m_trials[(m_rel - 2) / TRIAL_CYC], vco_stuck) - 256;
                end
                if (m_rel <= SEARCH_CYC) begin
                    exp_cal = m_trials[(m_rel - 1) / TRIAL_CYC];
                end else begin
                    m_run = 1'b0; exp_busy = 1'b0; exp_done = 1'b1; exp_cal = m_result;
                end
            end else if (start && !m_prev_start) begin
                plan_search(vco_stuck);
                m_run = 1'b1; m_rel = 1;
                exp_cal = 6'h20; exp_busy = 1'b1; exp_done = 1'b0;
            end
            m_prev_start = start;
        end
    end

    // Per-cycle comparison plus activity counters used by the directed checks.
    int  busy_cyc = 0;
    int  busy_rises = 0;
    int  evalid_cnt = 0;
    bit  prev_busy = 1'b0;

    always @(negedge clk) begin
        chk("cal", int'(cal), int'(exp_cal));
        chk("busy", int'(busy), int'(exp_busy));
        chk("done", int'(done), int'(exp_done));
`ifdef ETROC_AFC_ERR_OUT_EN
        chk("err_valid", int'(err_valid), int'(exp_evalid));
        chk("err", int'(err), exp_err);
        if (err_valid) evalid_cnt++;
`endif
        if (busy) busy_cyc++;
        if (busy && !prev_busy) busy_rises++;
        prev_busy = busy;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < SEARCH_CYC + 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: done still 0 after %0d cycles", tag, n);
        end
    endtask

    logic [5:0] want_tr [6] = '{6'h20, 6'h30, 6'h28, 6'h24, 6'h22, 6'h23};

    initial begin
        // Test 1: idle after reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("t1_cal", int'(cal), 32'h20);
        chk("t1_busy", int'(busy), 0);
        chk("t1_done", int'(done), 0);

        // Pin the search model against the hand-worked trial sequence
        plan_search(1'b0);
        for (int i = 0; i < 6; i++) chk($sformatf("model_trial%0d", i), int'(m_trials[i]), int'(want_tr[i]));
        chk("model_result", int'(m_result), 32'h23);

        // Test 2: full search with linear VCO
        busy_cyc = 0;
        pulse_start();
        wait_done("t2");
        @(negedge clk);
        chk("t2_cal", int'(cal), 32'h23);
        chk("t2_done", int'(done), 1);
        chk("t2_busy_cycles", busy_cyc, 7686);

        // Test 3: override
        @(posedge clk); #1 ovr = 1'b1; ovr_val = 6'h3C;
        @(posedge clk); @(negedge clk);
        chk("t3_ovr_cal", int'(cal), 32'h3C);
        chk("t3_ovr_done", int'(done), 0);
        pulse_start();
        repeat (20) @(posedge clk);
        #1 ovr_val = 6'h11;
        @(posedge clk); @(negedge clk);
        chk("t3_track_cal", int'(cal), 32'h11);
        chk("t3_ovr_busy", int'(busy), 0);
        @(posedge clk); #1 ovr_val = 6'h3C;
        repeat (3) @(posedge clk);
        #1 ovr = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("t3_release_cal", int'(cal), 32'h3C);
        chk("t3_release_busy", int'(busy), 0);

        // Test 4: reset during third trial
        pulse_start();
        repeat (2 * TRIAL_CYC + 300) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rst_cal", int'(cal), 32'h20);
        chk("t4_rst_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        pulse_start();
        wait_done("t4");
        @(negedge clk);
        chk("t4_cal", int'(cal), 32'h23);

        // Test 5: start held high across three search lengths
        busy_rises = 0;
        @(posedge clk); #1 start = 1'b1;
        repeat (3 * SEARCH_CYC + 200) @(posedge clk);
        @(negedge clk);
        chk("t5_one_run", busy_rises, 1);
        chk("t5_done", int'(done), 1);
        chk("t5_cal", int'(cal), 32'h23);
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        pulse_start();
        wait_done("t5");
        @(negedge clk);
        chk("t5_two_runs", busy_rises, 2);
        chk("t5_cal2", int'(cal), 32'h23);

        // Test 6: stuck feedback
        @(posedge clk); #1 vco_stuck = 1'b1; fb = 1'b0;
        repeat (10) @(posedge clk);
        evalid_cnt = 0;
        pulse_start();
        wait_done("t6");
        @(negedge clk);
        chk("t6_cal", int'(cal), 0);
        chk("t6_done", int'(done), 1);
`ifdef ETROC_AFC_ERR_OUT_EN
        chk("t6_err_pulses", evalid_cnt, 6);
        chk("t6_err", int'(err), -256);
`endif
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
